// File: rtl/branch_ctrl_pkg.sv
// Shared opcode, condition, flag-index and state definitions for the branch controller.
package branch_ctrl_pkg;

    localparam logic [4:0] OP_B   = 5'b10100;
    localparam logic [4:0] OP_BCC = 5'b10111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    function automatic logic [11:0] sext12(input logic [7:0] d);
        return {{4{d[7]}}, d};
    endfunction

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational evaluation of a Bcc condition against a {s,z,c,v} flag set.
module branch_cond_eval
    import branch_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       take,
    output logic       is_cond
);

    logic lt_s;
    logic unused_c_s;

    // Carry is kept in the flag register but no condition consumes it.
    assign unused_c_s = flags[FLAG_C];
    assign lt_s       = flags[FLAG_S] ^ flags[FLAG_V];

    // Condition table; the 1xx encodings are not branches at all.
    always_comb begin
        take    = 1'b0;
        is_cond = ~cond[2];
        case (cond)
            COND_BE:  take = flags[FLAG_Z];
            COND_BLT: take = lt_s;
            COND_BLE: take = flags[FLAG_Z] | lt_s;
            COND_BNE: take = ~flags[FLAG_Z];
            default:  take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: owns the PC and flag register, redirects on taken branches,
// squashes wrong-path fetch slots and stops on HLT.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter logic [11:0] RESET_PC     = 12'h000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic [3:0]  code_in,
    input  logic        code_we,
    input  logic        stall,
    output logic [11:0] pc,
    output logic [3:0]  flags,
    output logic        taken,
    output logic        squash,
    output logic        halted
);

    state_t      state_r;
    logic [11:0] pc_r;
    logic [3:0]  flags_r;
    logic [2:0]  cnt_r;
    logic        taken_r;
    logic        squash_r;
    logic        halted_r;

    logic        is_b_s;
    logic        is_bcc_s;
    logic        is_hlt_s;
    logic        branch_s;
    logic [3:0]  eval_flags_s;
    logic [11:0] target_s;
    logic        take_s;
    logic        is_cond_s;

    branch_cond_eval u_cond (
        .cond    (instr[10:8]),
        .flags   (eval_flags_s),
        .take    (take_s),
        .is_cond (is_cond_s)
    );

    // Instruction decode, flag bypass and branch target computation.
    always_comb begin
        is_b_s       = (instr[15:11] == OP_B);
        is_bcc_s     = (instr[15:11] == OP_BCC);
        is_hlt_s     = (instr[15:14] == 2'b11) && (instr[7:4] == 4'b1111);
        eval_flags_s = code_we ? code_in : flags_r;
        branch_s     = is_b_s || (is_bcc_s && is_cond_s && take_s);
        target_s     = pc_r + 12'd1 + sext12(instr[7:0]);
    end

    // PC, flag register and RUN/FLUSH/HALT sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            flags_r  <= 4'b0000;
            cnt_r    <= 3'd0;
            taken_r  <= 1'b0;
            squash_r <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            // Writeback is independent of fetch, so stall does not block it.
            if (code_we && (state_r != HALT)) begin
                flags_r <= code_in;
            end
            case (state_r)
                RUN: begin
                    if (!stall) begin
                        taken_r <= 1'b0;
                        if (instr_valid) begin
                            if (branch_s) begin
                                pc_r     <= target_s;
                                taken_r  <= 1'b1;
                                squash_r <= 1'b1;
                                cnt_r    <= 3'(FLUSH_CYCLES - 1);
                                state_r  <= FLUSH;
                            end else if (is_hlt_s) begin
                                halted_r <= 1'b1;
                                state_r  <= HALT;
                            end else begin
                                pc_r <= pc_r + 12'd1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        taken_r <= 1'b0;
                        if (cnt_r == 3'd0) begin
                            squash_r <= 1'b0;
                            state_r  <= RUN;
                        end else begin
                            cnt_r <= cnt_r - 3'd1;
                        end
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    assign pc     = pc_r;
    assign flags  = flags_r;
    assign taken  = taken_r;
    assign squash = squash_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl with hand-computed PC/flag values.
module tb_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  code_in;
    logic        code_we;
    logic        stall;
    logic [11:0] pc;
    logic [3:0]  flags;
    logic        taken;
    logic        squash;
    logic        halted;

    int passed = 0;
    int total  = 0;

    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [15:0] HLT = 16'hC0F0;

    branch_ctrl #(.RESET_PC(12'h000), .FLUSH_CYCLES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .code_in     (code_in),
        .code_we     (code_we),
        .stall       (stall),
        .pc          (pc),
        .flags       (flags),
        .taken       (taken),
        .squash      (squash),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] op_b(input logic [7:0] disp);
        return {5'b10100, 3'b000, disp};
    endfunction

    function automatic logic [15:0] op_bcc(input logic [2:0] cond, input logic [7:0] disp);
        return {5'b10111, cond, disp};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic we,
                        input logic [3:0] code, input logic st);
        instr_valid = v;
        instr       = ins;
        code_we     = we;
        code_in     = code;
        stall       = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = NOP;
        code_in = 4'b0000; code_we = 1'b0; stall = 1'b0;
        #7;
        chk("rst_pc", 16'(pc), 16'h000);
        chk("rst_flags", 16'(flags), 16'h0);
        chk("rst_taken", 16'(taken), 16'h0);
        chk("rst_squash", 16'(squash), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        #1 rst_n = 1'b1;

        // Sequential fetch
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0); chk("seq_pc1", 16'(pc), 16'h001);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0); chk("seq_pc2", 16'(pc), 16'h002);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0); chk("seq_pc3", 16'(pc), 16'h003);
        chk("seq_squash", 16'(squash), 16'h0);

        // Move to 010, then backward B F0 -> 001
        step(1'b1, op_b(8'h0C), 1'b0, 4'h0, 1'b0); chk("b_to_010", 16'(pc), 16'h010);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, op_b(8'hF0), 1'b0, 4'h0, 1'b0);
        chk("b_back_pc", 16'(pc), 16'h001);
        chk("b_back_taken", 16'(taken), 16'h1);
        chk("b_back_squash", 16'(squash), 16'h1);
        // Flush slot: a B here must be ignored
        step(1'b1, op_b(8'h10), 1'b0, 4'h0, 1'b0);
        chk("flush_ign_pc", 16'(pc), 16'h001);
        chk("flush_taken0", 16'(taken), 16'h0);
        chk("flush_squash0", 16'(squash), 16'h0);

        // Bypass: BE with code_we z=1 at 020 -> 026
        step(1'b1, op_b(8'h1E), 1'b0, 4'h0, 1'b0); chk("b_to_020", 16'(pc), 16'h020);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, op_bcc(3'b000, 8'h05), 1'b1, 4'b0100, 1'b0);
        chk("be_byp_pc", 16'(pc), 16'h026);
        chk("be_byp_flags", 16'(flags), 16'h4);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, op_b(8'hF9), 1'b0, 4'h0, 1'b0); chk("b_to_020b", 16'(pc), 16'h020);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        // Stored z=1 but bypassed z=0 -> not taken
        step(1'b1, op_bcc(3'b000, 8'h05), 1'b1, 4'b0000, 1'b0);
        chk("be_nt_pc", 16'(pc), 16'h021);
        chk("be_nt_taken", 16'(taken), 16'h0);

        // Conditions
        step(1'b1, NOP, 1'b1, 4'b1000, 1'b0); chk("set_sv10", 16'(flags), 16'h8);
        step(1'b1, op_bcc(3'b001, 8'h04), 1'b0, 4'h0, 1'b0);
        chk("blt_t_pc", 16'(pc), 16'h027);
        chk("blt_t_taken", 16'(taken), 16'h1);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, NOP, 1'b1, 4'b1001, 1'b0); chk("nop_pc028", 16'(pc), 16'h028);
        step(1'b1, op_bcc(3'b001, 8'h04), 1'b0, 4'h0, 1'b0);
        chk("blt_nt_pc", 16'(pc), 16'h029);
        chk("blt_nt_taken", 16'(taken), 16'h0);
        step(1'b1, NOP, 1'b1, 4'b0100, 1'b0);
        step(1'b1, op_bcc(3'b010, 8'h02), 1'b0, 4'h0, 1'b0);
        chk("ble_t_pc", 16'(pc), 16'h02D);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, op_bcc(3'b100, 8'h02), 1'b0, 4'h0, 1'b0);
        chk("cond1xx_pc", 16'(pc), 16'h02E);
        chk("cond1xx_taken", 16'(taken), 16'h0);

        // Wrap at FFF, then stall inside FLUSH
        step(1'b1, op_b(8'hD0), 1'b0, 4'h0, 1'b0); chk("b_to_fff", 16'(pc), 16'hFFF);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, op_b(8'h7F), 1'b0, 4'h0, 1'b0); chk("wrap_pc", 16'(pc), 16'h07F);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b1);
        step(1'b1, op_b(8'h10), 1'b0, 4'h0, 1'b1);
        chk("stall_pc", 16'(pc), 16'h07F);
        chk("stall_squash", 16'(squash), 16'h1);
        chk("stall_taken", 16'(taken), 16'h1);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        chk("unstall_pc", 16'(pc), 16'h07F);
        chk("unstall_squash", 16'(squash), 16'h0);

        // HLT at 030
        step(1'b1, op_b(8'hB0), 1'b0, 4'h0, 1'b0); chk("b_to_030", 16'(pc), 16'h030);
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        step(1'b1, HLT, 1'b0, 4'h0, 1'b0);
        chk("hlt_halted", 16'(halted), 16'h1);
        chk("hlt_pc", 16'(pc), 16'h030);
        step(1'b1, op_b(8'h10), 1'b1, 4'b1111, 1'b0);
        step(1'b1, NOP, 1'b1, 4'b1111, 1'b0);
        chk("halt_pc", 16'(pc), 16'h030);
        chk("halt_flags", 16'(flags), 16'h4);
        chk("halt_squash", 16'(squash), 16'h0);

        // Reset out of HALT, then reset mid-FLUSH
        rst_n = 1'b0; #1;
        chk("hrst_halted", 16'(halted), 16'h0);
        chk("hrst_pc", 16'(pc), 16'h000);
        @(negedge clk); rst_n = 1'b1;
        step(1'b1, op_b(8'h0F), 1'b1, 4'b1010, 1'b0);
        chk("pre_rst_pc", 16'(pc), 16'h010);
        chk("pre_rst_squash", 16'(squash), 16'h1);
        #2 rst_n = 1'b0; #1;
        chk("frst_pc", 16'(pc), 16'h000);
        chk("frst_taken", 16'(taken), 16'h0);
        chk("frst_squash", 16'(squash), 16'h0);
        chk("frst_flags", 16'(flags), 16'h0);
        @(negedge clk); rst_n = 1'b1;
        step(1'b1, NOP, 1'b0, 4'h0, 1'b0);
        chk("post_rst_pc", 16'(pc), 16'h001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
